// File: rtl/twiddle_bank_ram_if.sv
// rtl/twiddle_bank_ram_if.sv - load and read port bundle for twiddle_bank_ram
interface twiddle_bank_ram_if #(
  parameter int DLEN  = 32,
  parameter int HLEN  = 9,
  parameter int BLEN  = 1,
  parameter int BANKS = 2
);
  logic              ld_start;
  logic [BLEN-1:0]   ld_bank;
  logic              ld_valid;
  logic [DLEN-1:0]   ld_data;
  logic              ld_ready;
  logic              ld_busy;
  logic [BANKS-1:0]  bank_loaded;
  logic              rd_en;
  logic [BLEN-1:0]   rd_bank;
  logic [HLEN-1:0]   rd_addr;
  logic              rd_valid;
  logic [DLEN-1:0]   rd_data;
  logic              rd_miss;

  modport master (
    output ld_start, ld_bank, ld_valid, ld_data, rd_en, rd_bank, rd_addr,
    input  ld_ready, ld_busy, bank_loaded, rd_valid, rd_data, rd_miss
  );

  modport slave (
    input  ld_start, ld_bank, ld_valid, ld_data, rd_en, rd_bank, rd_addr,
    output ld_ready, ld_busy, bank_loaded, rd_valid, rd_data, rd_miss
  );
endinterface

// File: rtl/twiddle_bank_ram.sv
// rtl/twiddle_bank_ram.sv - multi-bank twiddle store with streamed load and pipelined read
module twiddle_bank_ram #(
  parameter int DLEN  = 32,
  parameter int HLEN  = 9,
  parameter int DEPTH = 1 << HLEN,
  parameter int BANKS = 2,
  parameter int BLEN  = 1,
  parameter int OREG  = 1
) (
  input  logic clk,
  input  logic reset,
  twiddle_bank_ram_if.slave bus
);
  localparam int              BW     = (BANKS > 1) ? $clog2(BANKS) : 1;
  localparam logic [BLEN:0]   NBANKS = (BLEN+1)'(BANKS);
  localparam logic [HLEN:0]   NWORDS = (HLEN+1)'(DEPTH);
  localparam logic [HLEN-1:0] LAST   = HLEN'(DEPTH - 1);

  typedef enum logic [1:0] {IDLE, LOAD, COMMIT} state_t;

  state_t            state_q, state_d;
  logic [BW-1:0]     bank_q;
  logic [HLEN-1:0]   cnt_q;
  logic [BANKS-1:0]  loaded_q;
  logic              ld_ready, ld_busy, take_start, beat, commit, start_ok;

  logic [DLEN-1:0]   mem [BANKS][DEPTH];
  logic [DLEN-1:0]   ram_q;
  logic              rd_bank_ok, rd_addr_ok, rd_hit;
  logic [BW-1:0]     rd_bi;
  logic [HLEN-1:0]   rd_ai;
  logic              v1, m1;
  logic [DLEN-1:0]   d1;

  assign start_ok = bus.ld_start && ({1'b0, bus.ld_bank} < NBANKS);

  always_comb begin
    state_d    = state_q;
    ld_ready   = 1'b0;
    ld_busy    = 1'b0;
    take_start = 1'b0;
    beat       = 1'b0;
    commit     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_ok) begin
          take_start = 1'b1;
          state_d    = LOAD;
        end
      end
      LOAD: begin
        ld_ready = 1'b1;
        ld_busy  = 1'b1;
        if (bus.ld_valid) begin
          beat = 1'b1;
          if (cnt_q == LAST) state_d = COMMIT;
        end
      end
      COMMIT: begin
        ld_busy = 1'b1;
        commit  = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= IDLE;
      bank_q   <= '0;
      cnt_q    <= '0;
      loaded_q <= '0;
    end else begin
      state_q <= state_d;
      if (take_start) begin
        bank_q                     <= BW'(bus.ld_bank);
        cnt_q                      <= '0;
        loaded_q[BW'(bus.ld_bank)] <= 1'b0;
      end
      if (beat)   cnt_q            <= cnt_q + 1'b1;
      if (commit) loaded_q[bank_q] <= 1'b1;
    end
  end

  assign bus.ld_ready    = ld_ready;
  assign bus.ld_busy     = ld_busy;
  assign bus.bank_loaded = loaded_q;

  // Out-of-range requests are steered to a legal index; their result is zeroed anyway.
  assign rd_bank_ok = {1'b0, bus.rd_bank} < NBANKS;
  assign rd_addr_ok = {1'b0, bus.rd_addr} < NWORDS;
  assign rd_bi      = rd_bank_ok ? BW'(bus.rd_bank) : '0;
  assign rd_ai      = rd_addr_ok ? bus.rd_addr : '0;
  assign rd_hit     = rd_bank_ok && rd_addr_ok && loaded_q[rd_bi] &&
                      !(ld_busy && (bank_q == rd_bi));

  // Read-first RAM: a same-address write this cycle is not visible to the read.
  always_ff @(posedge clk) begin
    if (beat)       mem[bank_q][cnt_q] <= bus.ld_data;
    if (bus.rd_en)  ram_q              <= mem[rd_bi][rd_ai];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      v1 <= 1'b0;
      m1 <= 1'b0;
    end else begin
      v1 <= bus.rd_en;
      m1 <= bus.rd_en && !rd_hit;
    end
  end

  assign d1 = (v1 && !m1) ? ram_q : '0;

  if (OREG != 0) begin : g_oreg
    logic            v2, m2;
    logic [DLEN-1:0] d2;
    always_ff @(posedge clk) begin
      if (reset) begin
        v2 <= 1'b0;
        m2 <= 1'b0;
        d2 <= '0;
      end else begin
        v2 <= v1;
        m2 <= m1;
        d2 <= d1;
      end
    end
    assign bus.rd_valid = v2;
    assign bus.rd_miss  = m2;
    assign bus.rd_data  = d2;
  end else begin : g_noreg
    assign bus.rd_valid = v1;
    assign bus.rd_miss  = m1;
    assign bus.rd_data  = d1;
  end
endmodule

// File: tb/tb_twiddle_bank_ram.sv
// tb/tb_twiddle_bank_ram.sv - randomized self-checking bench for twiddle_bank_ram
module tb_twiddle_bank_ram;
  localparam int DLEN  = 32;
  localparam int HLEN  = 9;
  localparam int DEPTH = 500;
  localparam int BANKS = 2;
  localparam int BLEN  = 2;
  localparam int OREG  = 1;
  localparam int LAT   = 1 + OREG;

  typedef struct {
    int             due;
    bit             miss;
    logic [DLEN-1:0] data;
  } rd_exp_t;

  logic clk = 1'b0;
  logic reset;

  twiddle_bank_ram_if #(.DLEN(DLEN), .HLEN(HLEN), .BLEN(BLEN), .BANKS(BANKS)) bus ();

  twiddle_bank_ram #(
    .DLEN(DLEN), .HLEN(HLEN), .DEPTH(DEPTH), .BANKS(BANKS), .BLEN(BLEN), .OREG(OREG)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  logic [DLEN-1:0] mdl_mem [BANKS][DEPTH];
  bit              mdl_loaded [BANKS];
  bit              mdl_active;
  int              mdl_bank;
  rd_exp_t         pend [$];
  int              cyc;
  int              checks;
  int              failures;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cycle=%0d", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [BANKS-1:0] loaded_vec();
    logic [BANKS-1:0] v;
    for (int i = 0; i < BANKS; i++) v[i] = mdl_loaded[i];
    return v;
  endfunction

  task automatic tick();
    rd_exp_t e;
    @(posedge clk);
    #1;
    cyc++;
    bus.rd_en    = 1'b0;
    bus.ld_start = 1'b0;
    bus.ld_valid = 1'b0;
    if (pend.size() > 0 && pend[0].due == cyc) begin
      e = pend.pop_front();
      chk("rd_valid", 64'(bus.rd_valid), 64'd1);
      chk("rd_miss",  64'(bus.rd_miss),  64'(e.miss));
      chk("rd_data",  64'(bus.rd_data),  64'(e.data));
    end else begin
      chk("rd_valid_idle", 64'(bus.rd_valid), 64'd0);
    end
  endtask

  task automatic read(input int b, input int a);
    rd_exp_t e;
    bit miss;
    bus.rd_en   = 1'b1;
    bus.rd_bank = b[BLEN-1:0];
    bus.rd_addr = a[HLEN-1:0];
    miss = (b >= BANKS) || (a >= DEPTH);
    if (!miss) miss = !mdl_loaded[b] || (mdl_active && mdl_bank == b);
    e.due  = cyc + LAT;
    e.miss = miss;
    e.data = miss ? '0 : mdl_mem[b][a];
    pend.push_back(e);
  endtask

  task automatic drain();
    repeat (LAT + 1) tick();
  endtask

  task automatic load_bank(input int b, input int base, input int rd_b, input int abort_at,
                           output bit aborted);
    int n;
    bit v;
    aborted      = 1'b0;
    bus.ld_start = 1'b1;
    bus.ld_bank  = b[BLEN-1:0];
    if (rd_b >= 0) read(rd_b, $urandom_range(0, DEPTH - 1));
    tick();
    if (b >= BANKS) begin
      chk("busy_ignored", 64'(bus.ld_busy), 64'd0);
      return;
    end
    mdl_loaded[b] = 1'b0;
    mdl_active    = 1'b1;
    mdl_bank      = b;
    chk("busy_start",  64'(bus.ld_busy),     64'd1);
    chk("loaded_drop", 64'(bus.bank_loaded), 64'(loaded_vec()));
    n = 0;
    while (n < DEPTH) begin
      if (abort_at >= 0 && n == abort_at) begin
        aborted = 1'b1;
        return;
      end
      chk("ld_ready", 64'(bus.ld_ready), 64'd1);
      v            = ($urandom_range(0, 3) != 0);
      bus.ld_valid = v;
      bus.ld_data  = DLEN'(base + n);
      if (rd_b >= 0) read(rd_b, $urandom_range(0, DEPTH - 1));
      tick();
      if (v) begin
        mdl_mem[b][n] = DLEN'(base + n);
        n++;
      end
    end
    chk("ready_commit",  64'(bus.ld_ready),    64'd0);
    chk("busy_commit",   64'(bus.ld_busy),     64'd1);
    chk("loaded_commit", 64'(bus.bank_loaded), 64'(loaded_vec()));
    if (rd_b >= 0) read(rd_b, $urandom_range(0, DEPTH - 1));
    tick();
    mdl_loaded[b] = 1'b1;
    mdl_active    = 1'b0;
    chk("loaded_set", 64'(bus.bank_loaded), 64'(loaded_vec()));
    chk("busy_idle",  64'(bus.ld_busy),     64'd0);
  endtask

  initial begin
    bit ab;
    checks     = 0;
    failures   = 0;
    cyc        = 0;
    mdl_active = 1'b0;
    mdl_bank   = 0;
    for (int i = 0; i < BANKS; i++) mdl_loaded[i] = 1'b0;
    reset        = 1'b1;
    bus.ld_start = 1'b0;
    bus.ld_bank  = '0;
    bus.ld_valid = 1'b0;
    bus.ld_data  = '0;
    bus.rd_en    = 1'b0;
    bus.rd_bank  = '0;
    bus.rd_addr  = '0;
    repeat (3) tick();
    chk("rst_ld_ready", 64'(bus.ld_ready),    64'd0);
    chk("rst_ld_busy",  64'(bus.ld_busy),     64'd0);
    chk("rst_loaded",   64'(bus.bank_loaded), 64'd0);
    chk("rst_rd_miss",  64'(bus.rd_miss),     64'd0);
    chk("rst_rd_data",  64'(bus.rd_data),     64'd0);
    reset = 1'b0;

    read(0, 5);
    tick();
    drain();

    load_bank(1, 32'h100, -1, -1, ab);
    read(1, 7);
    tick();
    drain();

    load_bank(0, 32'hA000_0000, -1, -1, ab);
    load_bank(1, 32'h200, 0, -1, ab);
    drain();

    load_bank(1, 32'h5500, 1, -1, ab);
    read(1, 7);
    tick();
    drain();

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 3) != 0) read($urandom_range(0, 3), $urandom_range(0, (1 << HLEN) - 1));
      tick();
    end
    drain();

    load_bank(0, 32'h7000, -1, 100, ab);
    chk("abort_reached", 64'(ab), 64'd1);
    reset = 1'b1;
    tick();
    for (int i = 0; i < BANKS; i++) mdl_loaded[i] = 1'b0;
    mdl_active = 1'b0;
    chk("abort_ld_ready", 64'(bus.ld_ready),    64'd0);
    chk("abort_ld_busy",  64'(bus.ld_busy),     64'd0);
    chk("abort_loaded",   64'(bus.bank_loaded), 64'd0);
    reset = 1'b0;
    read(0, 3);
    tick();
    drain();

    load_bank(0, 32'h3C00, -1, -1, ab);
    load_bank(3, 32'h9999, -1, -1, ab);
    tick();
    chk("busy_after_bad_start", 64'(bus.ld_busy), 64'd0);
    read(0, DEPTH);
    tick();
    read(0, DEPTH - 1);
    tick();
    read(0, (1 << HLEN) - 1);
    tick();
    read(3, 0);
    tick();
    drain();

    read(0, 1);
    tick();
    pend.delete();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    for (int i = 0; i < BANKS; i++) mdl_loaded[i] = 1'b0;
    read(0, 1);
    tick();
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
